// File: rtl/key_event_scheduler.sv
// Diffs successive HID key snapshots and streams make/break scan-code events
// on a valid/ready port, with an idle gap after every accepted event.
module key_event_scheduler #(
    parameter int SLOTS      = 14,
    parameter int CODE_W     = 9,
    parameter int GAP_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_ready,
    input  logic [SLOTS*CODE_W-1:0] fifo_din,
    output logic                    fifo_rd,
    input  logic                    clear,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [CODE_W-1:0]       evt_code,
    output logic                    evt_break,
    output logic                    busy,
    output logic [2:0]              dbg_state
);
    localparam int REPORT_W = SLOTS * CODE_W;
    localparam int IDX_W    = $clog2(SLOTS + 1);
    localparam int GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN_BRK,
        S_SCAN_MK,
        S_EMIT,
        S_GAP,
        S_COMMIT
    } state_t;

    state_t              state_q;
    logic [REPORT_W-1:0] prev_q;
    logic [REPORT_W-1:0] cur_q;
    logic [IDX_W-1:0]    idx_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                evt_valid_q;
    logic [CODE_W-1:0]   evt_code_q;
    logic                evt_break_q;
    logic                busy_q;

    logic [REPORT_W-1:0] scan_own_d;
    logic [REPORT_W-1:0] scan_other_d;
    logic [CODE_W-1:0]   scan_code_d;
    logic                scan_hit_d;
    logic                phase_brk_d;
    state_t              adv_state_d;
    logic [IDX_W-1:0]    adv_idx_d;

    // Slot n is 1-based; slot 1 sits in the most significant bits.
    function automatic logic [CODE_W-1:0] slot_code(input logic [REPORT_W-1:0] r, input int n);
        if (n < 1 || n > SLOTS) begin
            return '0;
        end
        return r[REPORT_W - n*CODE_W +: CODE_W];
    endfunction

    // A slot qualifies when it is active in its own snapshot (nonzero, first
    // occurrence) and its code appears nowhere in the other snapshot.
    always_comb begin
        scan_own_d   = (state_q == S_SCAN_MK) ? cur_q : prev_q;
        scan_other_d = (state_q == S_SCAN_MK) ? prev_q : cur_q;
        scan_code_d  = slot_code(scan_own_d, int'(idx_q));
        scan_hit_d   = (scan_code_d != '0);
        for (int j = 1; j <= SLOTS; j++) begin
            if (j < int'(idx_q) && slot_code(scan_own_d, j) == scan_code_d) begin
                scan_hit_d = 1'b0;
            end
            if (slot_code(scan_other_d, j) == scan_code_d) begin
                scan_hit_d = 1'b0;
            end
        end
    end

    // Where the scan goes after the current slot; EMIT and GAP recover the
    // phase from the polarity of the event just sent.
    always_comb begin
        phase_brk_d = (state_q == S_SCAN_BRK) ||
                      ((state_q == S_EMIT || state_q == S_GAP) && evt_break_q);
        adv_state_d = phase_brk_d ? S_SCAN_BRK : S_SCAN_MK;
        adv_idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(SLOTS)) begin
            adv_state_d = phase_brk_d ? S_SCAN_MK : S_COMMIT;
            adv_idx_d   = IDX_W'(1);
        end
    end

    // Handshake: an event transfers on a rising clk edge where evt_valid and
    // evt_ready are both high; evt_code/evt_break hold until that edge and
    // evt_valid never drops without a transfer. GAP lasts GAP_CYCLES-1 cycles
    // so the following scan cycle completes the GAP_CYCLES idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            cur_q       <= '0;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= '0;
            evt_break_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        cur_q   <= '0;
                        idx_q   <= IDX_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN_BRK;
                    end else if (fifo_ready) begin
                        cur_q   <= fifo_din;
                        idx_q   <= IDX_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN_BRK;
                    end
                end
                S_SCAN_BRK, S_SCAN_MK: begin
                    if (scan_hit_d) begin
                        evt_code_q  <= scan_code_d;
                        evt_break_q <= (state_q == S_SCAN_BRK);
                        evt_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end else begin
                        idx_q   <= adv_idx_d;
                        state_q <= adv_state_d;
                    end
                end
                S_EMIT: begin
                    if (evt_ready) begin
                        evt_valid_q <= 1'b0;
                        if (GAP_CYCLES > 1) begin
                            gap_cnt_q <= GAP_W'(GAP_CYCLES > 1 ? GAP_CYCLES - 2 : 0);
                            state_q   <= S_GAP;
                        end else begin
                            idx_q   <= adv_idx_d;
                            state_q <= adv_state_d;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        idx_q   <= adv_idx_d;
                        state_q <= adv_state_d;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                S_COMMIT: begin
                    prev_q  <= cur_q;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd   = !reset && (state_q == S_IDLE) && !clear && fifo_ready;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_break = evt_break_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
